// File: rtl/step_dir_decoder.sv
// Step/direction receiver: synchronises pulse/dirction, tracks signed position and step period,
// flags interface timing violations and reports end of motion after an idle timeout.
module step_dir_decoder #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PER_W        = 24,
  parameter int unsigned MIN_HIGH     = 2,
  parameter int unsigned DIR_SETUP    = 2,
  parameter int unsigned IDLE_TIMEOUT = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pulse,
  input  logic                    dirction,
  input  logic                    load_pos,
  input  logic signed [CNT_W-1:0] load_value,
  input  logic                    clr_pos,
  input  logic                    clr_err,
  output logic signed [CNT_W-1:0] position,
  output logic        [CNT_W-1:0] step_cnt,
  output logic        [PER_W-1:0] period,
  output logic                    period_valid,
  output logic                    moving,
  output logic                    stop_int,
  output logic        [2:0]       err_flags
);

  localparam int unsigned HwW = $clog2(MIN_HIGH + 2);
  localparam int unsigned DsW = $clog2(DIR_SETUP + 2);
  localparam int unsigned IdW = $clog2(IDLE_TIMEOUT + 2);

  localparam logic [HwW-1:0] MinHigh  = HwW'(MIN_HIGH);
  localparam logic [DsW-1:0] DirSetup = DsW'(DIR_SETUP);
  localparam logic [IdW-1:0] IdleTo   = IdW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StFirst, StRun} state_e;

  state_e state_q, state_d;

  logic p_s1_q, p_s2_q, p_s3_q;
  logic d_s1_q, d_s2_q;
  logic rise, fall;

  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [HwW-1:0]   hw_q, hw_d;
  logic [DsW-1:0]   ds_q, ds_d;
  logic [IdW-1:0]   idle_q, idle_d;

  logic signed [CNT_W-1:0] pos_q, pos_d;
  logic        [CNT_W-1:0] step_q, step_d;
  logic        [CNT_W-1:0] step_delta;
  logic        [PER_W-1:0] period_q, period_d;
  logic                    pv_q, pv_d;
  logic                    stop_q, stop_d;
  logic        [2:0]       err_q, err_d;

  logic short_err, dir_err, sat_err, timeout;

  assign rise = p_s2_q & ~p_s3_q;
  assign fall = ~p_s2_q & p_s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_s1_q <= 1'b0;
      p_s2_q <= 1'b0;
      p_s3_q <= 1'b0;
      d_s1_q <= 1'b0;
      d_s2_q <= 1'b0;
    end else begin
      p_s1_q <= pulse;
      p_s2_q <= p_s1_q;
      p_s3_q <= p_s2_q;
      d_s1_q <= dirction;
      d_s2_q <= d_s1_q;
    end
  end

  // Free-running measurement counters; all saturate rather than wrap.
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (rise) begin
      per_cnt_d = PER_W'(1);
    end else if (per_cnt_q != '1) begin
      per_cnt_d = per_cnt_q + PER_W'(1);
    end

    hw_d = '0;
    if (p_s2_q) begin
      hw_d = (hw_q == '1) ? hw_q : hw_q + HwW'(1);
    end

    // Zeroed on the edge where the synced direction takes its new value.
    ds_d = ds_q;
    if (d_s1_q != d_s2_q) begin
      ds_d = '0;
    end else if (ds_q != '1) begin
      ds_d = ds_q + DsW'(1);
    end

    idle_d = idle_q;
    if (rise) begin
      idle_d = IdW'(1);
    end else if (idle_q != '1) begin
      idle_d = idle_q + IdW'(1);
    end
  end

  assign short_err = fall && (hw_q < MinHigh);
  assign dir_err   = rise && (ds_q < DirSetup);
  assign timeout   = (idle_q == IdleTo);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    pv_d     = 1'b0;
    stop_d   = 1'b0;
    sat_err  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StFirst;
      end
      StFirst, StRun: begin
        if (rise) begin
          state_d  = StRun;
          period_d = per_cnt_q;
          pv_d     = 1'b1;
          sat_err  = (per_cnt_q == '1);
        end else if (timeout) begin
          state_d = StIdle;
          stop_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign step_delta = d_s2_q ? CNT_W'(1) : '1;

  always_comb begin
    pos_d  = pos_q;
    step_d = step_q;
    if (load_pos) begin
      pos_d = load_value;
    end else if (clr_pos) begin
      pos_d  = '0;
      step_d = '0;
    end else if (rise) begin
      pos_d  = pos_q + step_delta;
      step_d = (state_q == StIdle) ? CNT_W'(1) : step_q + CNT_W'(1);
    end

    // A new error in the clearing cycle still lands.
    err_d = clr_err ? 3'b000 : err_q;
    err_d = err_d | {sat_err, dir_err, short_err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      per_cnt_q <= '0;
      hw_q      <= '0;
      ds_q      <= '0;
      idle_q    <= '0;
      pos_q     <= '0;
      step_q    <= '0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      stop_q    <= 1'b0;
      err_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      hw_q      <= hw_d;
      ds_q      <= ds_d;
      idle_q    <= idle_d;
      pos_q     <= pos_d;
      step_q    <= step_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      stop_q    <= stop_d;
      err_q     <= err_d;
    end
  end

  assign position     = pos_q;
  assign step_cnt     = step_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign moving       = (state_q != StIdle);
  assign stop_int     = stop_q;
  assign err_flags    = err_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: directed sequences, an error-timing vector table, and randomised
// pulse trains checked against a transaction-level model.
module tb_step_dir_decoder;

  localparam int unsigned CW = 32;
  localparam int unsigned PW = 10;
  localparam int unsigned MH = 2;
  localparam int unsigned DS = 2;
  localparam int unsigned TO = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pulse = 1'b0;
  logic          dirction = 1'b0;
  logic          load_pos = 1'b0;
  logic [CW-1:0] load_value = '0;
  logic          clr_pos = 1'b0;
  logic          clr_err = 1'b0;
  logic [CW-1:0] position;
  logic [CW-1:0] step_cnt;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          moving;
  logic          stop_int;
  logic [2:0]    err_flags;

  step_dir_decoder #(
    .CNT_W       (CW),
    .PER_W       (PW),
    .MIN_HIGH    (MH),
    .DIR_SETUP   (DS),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pulse       (pulse),
    .dirction    (dirction),
    .load_pos    (load_pos),
    .load_value  (load_value),
    .clr_pos     (clr_pos),
    .clr_err     (clr_err),
    .position    (position),
    .step_cnt    (step_cnt),
    .period      (period),
    .period_valid(period_valid),
    .moving      (moving),
    .stop_int    (stop_int),
    .err_flags   (err_flags)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pv_cnt = 0;
  int stop_cnt = 0;
  int stop_cyc = 0;
  int rise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (period_valid) pv_cnt <= pv_cnt + 1;
    if (stop_int) begin
      stop_cnt <= stop_cnt + 1;
      stop_cyc <= cyc;
    end
  end

  typedef struct {
    int         high;
    int         lead;
    logic       toggle;
    logic [2:0] exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // L low cycles then H high cycles; dirction takes nd D cycles before the rising edge.
  task automatic do_pulse(input int l, input int h, input int d, input logic nd, input logic clr,
                          input int tail);
    for (int c = 0; c < l + h; c++) begin
      if (c == l - d) dirction = nd;
      pulse   = (c >= l);
      clr_err = clr && (c == 0);
      if (c == l) rise_cyc = cyc;
      tick();
    end
    clr_err = 1'b0;
    pulse   = 1'b0;
    repeat (tail) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] exp_pos;
    logic [CW-1:0] exp_step;
    logic [CW-1:0] exp_per;
    logic [2:0]    exp_err;
    int            pv_base;
    int            sb;
    int            n;
    logic          nd;
    logic          cur;
    int            l, h, d, prev_ht, pv_exp;
    logic          chg, clr, first;

    vecs[0] = '{high: 1, lead: 6, toggle: 1'b0, exp_err: 3'b001};
    vecs[1] = '{high: 2, lead: 6, toggle: 1'b0, exp_err: 3'b000};
    vecs[2] = '{high: 4, lead: 1, toggle: 1'b1, exp_err: 3'b010};
    vecs[3] = '{high: 4, lead: 2, toggle: 1'b1, exp_err: 3'b000};
    vecs[4] = '{high: 4, lead: 0, toggle: 1'b1, exp_err: 3'b010};
    vecs[5] = '{high: 1, lead: 1, toggle: 1'b1, exp_err: 3'b011};
    vecs[6] = '{high: 3, lead: 6, toggle: 1'b1, exp_err: 3'b000};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (1000) tick();
    chk("rst_position", position, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_period", period, 0);
    chk("rst_period_valid", period_valid, 0);
    chk("rst_moving", moving, 0);
    chk("rst_stop_int", stop_int, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_no_strobes", pv_cnt + stop_cnt, 0);

    // Long forward move then timeout
    pv_base = pv_cnt;
    sb = stop_cnt;
    for (int i = 0; i < 300; i++) do_pulse(10, 10, 10, 1'b1, 1'b0, 0);
    repeat (5) tick();
    chk("run_position", position, 300);
    chk("run_step_cnt", step_cnt, 300);
    chk("run_period", period, 20);
    chk("run_pv_count", pv_cnt - pv_base, 299);
    chk("run_moving", moving, 1);
    chk("run_err", err_flags, 0);
    n = 0;
    while (stop_cnt == sb && n < int'(TO) + 100) begin
      tick();
      n++;
    end
    repeat (5) tick();
    chk("stop_once", stop_cnt - sb, 1);
    chk("stop_latency", stop_cyc - rise_cyc, TO + 3);
    chk("stop_moving", moving, 0);
    chk("stop_period_held", period, 20);

    // Preset then reverse, then wrap
    load_value = 5;
    load_pos = 1'b1;
    tick();
    load_pos = 1'b0;
    chk("load_position", position, 5);
    for (int i = 0; i < 10; i++) do_pulse(5, 5, 5, 1'b0, 1'b0, 0);
    repeat (5) tick();
    chk("rev_position", position, 32'hFFFF_FFFB);
    chk("rev_step_cnt", step_cnt, 10);
    chk("rev_period", period, 10);
    load_value = 32'h7FFF_FFFF;
    load_pos = 1'b1;
    tick();
    load_pos = 1'b0;
    do_pulse(5, 5, 5, 1'b1, 1'b0, 4);
    chk("wrap_position", position, 32'h8000_0000);
    chk("wrap_step_cnt", step_cnt, 11);
    chk("wrap_err", err_flags, 0);

    // Error timing table
    exp_pos = 32'h8000_0000;
    exp_step = 11;
    foreach (vecs[i]) begin
      nd = vecs[i].toggle ? ~dirction : dirction;
      do_pulse(8, vecs[i].high, vecs[i].lead, nd, 1'b1, 5);
      exp_pos = nd ? exp_pos + 1 : exp_pos - 1;
      exp_step = exp_step + 1;
      chk($sformatf("vec%0d_err", i), err_flags, vecs[i].exp_err);
      chk($sformatf("vec%0d_position", i), position, exp_pos);
      chk($sformatf("vec%0d_step_cnt", i), step_cnt, exp_step);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err", err_flags, 0);

    // Period saturation
    do_pulse(5, 5, 5, dirction, 1'b0, 0);
    do_pulse(1495, 5, 5, dirction, 1'b0, 4);
    chk("sat_period", period, 10'h3FF);
    chk("sat_err", err_flags, 3'b100);
    chk("sat_moving", moving, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // load_pos in the same cycle as a detected step
    exp_step = step_cnt;
    load_value = 32'h0000_1234;
    pulse = 1'b1;
    tick();
    tick();
    load_pos = 1'b1;
    tick();
    load_pos = 1'b0;
    repeat (3) tick();
    pulse = 1'b0;
    repeat (5) tick();
    chk("loadstep_position", position, 32'h0000_1234);
    chk("loadstep_step_cnt", step_cnt, exp_step);

    // clr_pos mid-move
    clr_pos = 1'b1;
    tick();
    clr_pos = 1'b0;
    chk("clrpos_position", position, 0);
    chk("clrpos_step_cnt", step_cnt, 0);
    chk("clrpos_moving", moving, 1);
    do_pulse(5, 5, 5, 1'b1, 1'b0, 4);
    chk("clrpos_next_position", position, 1);
    chk("clrpos_next_step_cnt", step_cnt, 1);

    // Asynchronous reset mid-move
    sb = stop_cnt;
    rst_n = 1'b0;
    #2;
    chk("arst_position", position, 0);
    chk("arst_moving", moving, 0);
    chk("arst_period", period, 0);
    dirction = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("arst_no_stop", stop_cnt - sb, 0);
    chk("arst_step_cnt", step_cnt, 0);

    // Randomised pulse trains against a transaction-level model
    exp_pos = 0;
    exp_step = 0;
    exp_per = 0;
    exp_err = 3'b000;
    cur = 1'b0;
    first = 1'b1;
    prev_ht = 0;
    pv_exp = 0;
    pv_base = pv_cnt;
    for (int i = 0; i < 200; i++) begin
      l = int'($urandom_range(1, 8));
      h = int'($urandom_range(1, 6));
      d = int'($urandom_range(0, l));
      chg = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      nd = chg ? ~cur : cur;
      do_pulse(l, h, d, nd, clr, 3);
      if (clr) exp_err = 3'b000;
      if (chg && d < int'(DS)) exp_err[1] = 1'b1;
      if (h < int'(MH)) exp_err[0] = 1'b1;
      exp_pos = nd ? exp_pos + 1 : exp_pos - 1;
      if (first) begin
        exp_step = 1;
        first = 1'b0;
      end else begin
        exp_step = exp_step + 1;
        exp_per = prev_ht + l;
        pv_exp++;
      end
      prev_ht = h + 3;
      cur = nd;
      chk($sformatf("rnd%0d_position", i), position, exp_pos);
      chk($sformatf("rnd%0d_step_cnt", i), step_cnt, exp_step);
      chk($sformatf("rnd%0d_period", i), period, exp_per);
      chk($sformatf("rnd%0d_err", i), err_flags, exp_err);
    end
    chk("rnd_pv_count", pv_cnt - pv_base, pv_exp);
    chk("rnd_moving", moving, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
